button_press_classifier: RTL
============================

BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000; consecutive stable cycles needed to accept a level change.
REQ-002 Parameter LONG_CYCLES, default 100_000_000; debounced hold time at which a press becomes long.
REQ-003 Parameter STRETCH_CYCLES, default 100_000_000; short-pulse width when stretching is compiled in.
REQ-004 Port clk  input  1  single system clock; all logic on posedge clk.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port btn0, btn1  input  1 each  raw asynchronous push-buttons, 1 = pressed.
REQ-007 Port b0short, b1short  output  1 each  short-press event.
REQ-008 Port b0long, b1long  output  1 each  long-press level.
REQ-009 Port b0_db, b1_db  output  1 each  debounced button level.

Function
REQ-010 Each button SHALL be handled by an independent, identical channel; channels SHALL NOT interact.
REQ-011 Raw input SHALL pass a 2-flop synchronizer; the synchronized sample is s.
REQ-012 Debounced level d SHALL change only after s differs from d for DEBOUNCE_CYCLES consecutive cycles; d SHALL update on the following edge; any matching sample SHALL clear the stability counter.
REQ-013 Press FSM per channel: IDLE, HELD, LONG, WAIT_REL.
REQ-014 IDLE: d rising -> HELD, hold counter cleared to 0.
REQ-015 HELD: counter increments each cycle. If d falls before the counter reaches LONG_CYCLES-1 -> IDLE with the short output asserted for exactly one cycle. If the counter reaches LONG_CYCLES-1 -> LONG.
REQ-016 LONG: the long output SHALL be 1 for every cycle in LONG. When d falls -> IDLE and long deasserts on that edge. No short event SHALL be generated.
REQ-017 WAIT_REL: entered from any state when d=1 after reset. Stays until d=0, then -> IDLE. No events SHALL be generated in WAIT_REL.
REQ-018 The hold counter SHALL be 28 bits, saturating, and SHALL never wrap.
REQ-019 A press held for exactly LONG_CYCLES debounced cycles SHALL be long, not short.
REQ-020 Total latency from a raw edge to the d change SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-021 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no d change and no events.
REQ-022 Simultaneous events on both channels SHALL both be reported in the same cycle.

Reset
REQ-023 While rst=1, the following SHALL all be 0: all outputs, synchronizers, d, counters, and stretch counters; FSM in IDLE.
REQ-024 On the first cycle after rst deasserts, a channel whose d becomes 1 SHALL take the path IDLE->HELD only via a d rising edge. A button already held through reset SHALL enter WAIT_REL and emit nothing until released.
REQ-025 Asserting rst mid-press or mid-stretch SHALL abort it with no residual pulse.

Configuration
REQ-026 Macro BTN_SHORT_STRETCH_EN: when defined, each short event SHALL hold the short output high for STRETCH_CYCLES cycles. A new short event during a stretch SHALL restart the stretch counter. When undefined, the short output SHALL be a single-cycle pulse and STRETCH_CYCLES is unused.

Structure
REQ-027 Package btn_pkg SHALL hold the FSM state enum (2 bits), the counter width constant (28), and the synchronizer depth (2).
REQ-028 Sub-module btn_channel SHALL implement the synchronizer, debounce, FSM and stretch for one button. The top module SHALL instantiate it twice.

Verification
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, STRETCH_CYCLES=8.
REQ-029 Scenario: btn0 high for 10 cycles, then low.
  - b0short pulses 1 cycle, about 7 cycles after release.
  - b0long stays 0.
  - b1 outputs stay 0.
REQ-030 Scenario: btn1 high for 40 cycles.
  - b1long rises 27 cycles after the press edge.
  - b1long falls 7 cycles after release.
  - b1short never asserts.
REQ-031 Scenario: btn0 pulsed high for 3 cycles, repeated 5 times with 2-cycle gaps.
  - b0_db stays 0.
  - No events.
REQ-032 Scenario: btn1 held while rst=1, rst released, hold 30 more cycles, then release.
  - No short or long events at any point.
  - A following 10-cycle press yields one b1short.
REQ-033 Scenario, with BTN_SHORT_STRETCH_EN defined: btn0 short press.
  - b0short is high for exactly 8 cycles.
REQ-034 Scenario: both buttons pressed for 10 cycles with identical timing.
  - b0short and b1short pulse in the same cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and constants for the button press classifier
package btn_pkg;

    localparam int CNT_W      = 28;
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
        ST_LONG     = 2'd2,
        ST_WAIT_REL = 2'd3
    } btn_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// rtl/button_press_classifier_if.sv - raw buttons in, debounced levels and press events out
interface button_press_classifier_if;

    logic btn0;
    logic btn1;
    logic b0short;
    logic b1short;
    logic b0long;
    logic b1long;
    logic b0_db;
    logic b1_db;

    modport master (
        output btn0, btn1,
        input  b0short, b1short, b0long, b1long, b0_db, b1_db
    );

    modport slave (
        input  btn0, btn1,
        output b0short, b1short, b0long, b1long, b0_db, b1_db
    );

endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchronizer, debounce, press FSM, short output
// BTN_SHORT_STRETCH_EN stretches each short event to STRETCH_CYCLES cycles.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int STRETCH_CYCLES  = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_short,
    output logic o_long,
    output logic o_db
);

    localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam int                WARM_W    = $clog2(SYNC_DEPTH + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_DEPTH);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [DB_W-1:0]       r_db_cnt;
    logic                  r_db;
    logic [WARM_W-1:0]     r_warm;
    logic                  r_armed;
    btn_state_e            r_state;
    logic [CNT_W-1:0]      r_hold_cnt;
    logic                  r_long;
    logic                  r_short;

    logic w_s;
    logic w_db_next;
    logic w_short_evt;

    assign w_s = r_sync[SYNC_DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_btn};
        end
    end

    // The FSM reacts on the same edge the debounced level updates.
    assign w_db_next = ((w_s != r_db) && (r_db_cnt == DB_LAST)) ? w_s : r_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt <= '0;
            r_db     <= 1'b0;
        end else if (w_s == r_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db     <= w_s;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Arm only once a released sample has come through the synchronizer after reset,
    // so a button held through reset is routed to WAIT_REL instead of HELD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm  <= '0;
            r_armed <= 1'b0;
        end else if (r_warm != WARM_DONE) begin
            r_warm <= r_warm + 1'b1;
        end else if (!w_s) begin
            r_armed <= 1'b1;
        end
    end

    assign w_short_evt = (r_state == ST_HELD) && (r_hold_cnt != LONG_LAST) && !w_db_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_db_next) begin
                        r_hold_cnt <= '0;
                        r_state    <= r_armed ? ST_HELD : ST_WAIT_REL;
                    end
                end
                ST_HELD: begin
                    // Reaching the long threshold wins even if the level drops on this edge.
                    if (r_hold_cnt == LONG_LAST) begin
                        r_state    <= ST_LONG;
                        r_long     <= 1'b1;
                        r_hold_cnt <= sat_inc(r_hold_cnt);
                    end else if (!w_db_next) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= sat_inc(r_hold_cnt);
                    end
                end
                ST_LONG: begin
                    if (!w_db_next) begin
                        r_state <= ST_IDLE;
                        r_long  <= 1'b0;
                    end else begin
                        r_hold_cnt <= sat_inc(r_hold_cnt);
                    end
                end
                ST_WAIT_REL: begin
                    if (!w_db_next) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_long  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTN_SHORT_STRETCH_EN
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);

    logic [CNT_W-1:0] r_str_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_short   <= 1'b0;
            r_str_cnt <= '0;
        end else if (w_short_evt) begin
            r_short   <= 1'b1;
            r_str_cnt <= STR_LAST;
        end else if (r_str_cnt != '0) begin
            r_str_cnt <= r_str_cnt - 1'b1;
        end else begin
            r_short <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_short <= 1'b0;
        end else begin
            r_short <= w_short_evt;
        end
    end
`endif

    assign o_short = r_short;
    assign o_long  = r_long;
    assign o_db    = r_db;

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - two independent button channels (short/long press)
// BTN_SHORT_STRETCH_EN stretches each short event to STRETCH_CYCLES cycles.
module button_press_classifier
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 100_000_000,
    parameter int STRETCH_CYCLES  = 100_000_000
) (
    input logic                        clk,
    input logic                        rst,
    button_press_classifier_if.slave   bus
);

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .STRETCH_CYCLES  (STRETCH_CYCLES)
    ) u_ch0 (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn0),
        .o_short (bus.b0short),
        .o_long  (bus.b0long),
        .o_db    (bus.b0_db)
    );

    btn_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .STRETCH_CYCLES  (STRETCH_CYCLES)
    ) u_ch1 (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (bus.btn1),
        .o_short (bus.b1short),
        .o_long  (bus.b1long),
        .o_db    (bus.b1_db)
    );

endmodule
